// File: rtl/ifa_bus_arbiter.sv
`default_nettype none
// ============================================================================
// ifa_bus_arbiter : round-robin arbiter and START/WAIT sequencer for ifa bus
// Revision 1.0
// ============================================================================
module ifa_bus_arbiter #(
  parameter int NREQ    = 4,
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_i,
  input  logic [NREQ*AW-1:0] addr_i,
  input  logic [NREQ*2-1:0] mode_i,
  input  logic [NREQ*DW-1:0] wdata_i,
  output logic [NREQ-1:0]   gnt_o,
  output logic [NREQ-1:0]   done_o,
  output logic              err_o,
  output logic [DW-1:0]     rdata_o,
  output logic              bus_req,
  output logic              bus_start,
  output logic [AW-1:0]     bus_addr,
  output logic [1:0]        bus_mode,
  output logic [DW-1:0]     bus_wdata,
  output logic              bus_data_oe,
  input  logic              bus_rdy,
  input  logic [DW-1:0]     bus_rdata
);

  localparam int PW = $clog2(NREQ);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [PW:0]   C_NREQ  = (PW+1)'(NREQ);
  localparam logic [TW-1:0] C_TLAST = TW'(TIMEOUT - 1);

  localparam logic [1:0] C_IDLE  = 2'd0;
  localparam logic [1:0] C_START = 2'd1;
  localparam logic [1:0] C_WAIT  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [PW-1:0]   ptr_q;
  logic [PW-1:0]   idx_q;
  logic [TW-1:0]   timer_q;
  logic [NREQ-1:0] gnt_q;
  logic [NREQ-1:0] done_q;
  logic            err_q;
  logic [DW-1:0]   rdata_q;
  logic [AW-1:0]   addr_q;
  logic [1:0]      mode_q;
  logic [DW-1:0]   wdata_q;

  logic [NREQ-1:0] w_req_m;
  logic            w_found;
  logic [PW-1:0]   w_win;
  logic [PW:0]     w_j;
  logic [NREQ-1:0] w_win_oh;
  logic [AW-1:0]   w_sel_addr;
  logic [1:0]      w_sel_mode;
  logic [DW-1:0]   w_sel_wdata;
  logic [PW:0]     w_inc;
  logic [PW-1:0]   w_ptr_next;
  logic            w_exit;

  // The requester completing this cycle is masked so it can drop req_i on done_o.
  assign w_req_m = req_i & ~done_q;

  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_j     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_j = {1'b0, ptr_q} + (PW+1)'(k);
      if (w_j >= C_NREQ) w_j = w_j - C_NREQ;
      if (w_req_m[w_j[PW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_j[PW-1:0];
      end
    end
  end

  always_comb begin
    w_win_oh    = '0;
    w_sel_addr  = '0;
    w_sel_mode  = '0;
    w_sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win == PW'(i)) begin
        w_win_oh[i] = 1'b1;
        w_sel_addr  = addr_i[i*AW +: AW];
        w_sel_mode  = mode_i[i*2 +: 2];
        w_sel_wdata = wdata_i[i*DW +: DW];
      end
    end
  end

  assign w_inc      = {1'b0, idx_q} + (PW+1)'(1);
  assign w_ptr_next = (w_inc == C_NREQ) ? '0 : w_inc[PW-1:0];
  assign w_exit     = (state_q == C_WAIT) && (bus_rdy || (timer_q == C_TLAST));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= C_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      C_IDLE:  if (w_found) state_d = C_START;
      C_START: state_d = C_WAIT;
      C_WAIT:  if (w_exit) state_d = C_IDLE;
      default: state_d = C_IDLE;
    endcase
  end

  always_comb begin
    bus_req   = 1'b0;
    bus_start = 1'b0;
    case (state_q)
      C_START: begin
        bus_req   = 1'b1;
        bus_start = 1'b1;
      end
      C_WAIT:  bus_req = 1'b1;
      default: ;
    endcase
    bus_data_oe = bus_req & mode_q[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q   <= '0;
      idx_q   <= '0;
      timer_q <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      addr_q  <= '0;
      mode_q  <= '0;
      wdata_q <= '0;
    end else begin
      done_q <= '0;
      err_q  <= 1'b0;
      case (state_q)
        C_IDLE: begin
          if (w_found) begin
            gnt_q   <= w_win_oh;
            idx_q   <= w_win;
            addr_q  <= w_sel_addr;
            mode_q  <= w_sel_mode;
            wdata_q <= w_sel_wdata;
          end
        end
        C_START: timer_q <= '0;
        C_WAIT: begin
          if (w_exit) begin
            done_q  <= gnt_q;
            err_q   <= ~bus_rdy;
            if (bus_rdy && !mode_q[0]) rdata_q <= bus_rdata;
            gnt_q   <= '0;
            ptr_q   <= w_ptr_next;
            addr_q  <= '0;
            mode_q  <= '0;
            wdata_q <= '0;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign gnt_o     = gnt_q;
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign rdata_o   = rdata_q;
  assign bus_addr  = addr_q;
  assign bus_mode  = mode_q;
  assign bus_wdata = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_ifa_bus_arbiter.sv
`default_nettype none
// ============================================================================
// tb_ifa_bus_arbiter : scoreboard bench for ifa_bus_arbiter
// Revision 1.0
// ============================================================================
module tb_ifa_bus_arbiter;
  localparam int NREQ    = 4;
  localparam int AW      = 8;
  localparam int DW      = 8;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_i = '0;
  logic [NREQ*AW-1:0] addr_i = '0;
  logic [NREQ*2-1:0] mode_i = '0;
  logic [NREQ*DW-1:0] wdata_i = '0;
  logic [NREQ-1:0]   gnt_o, done_o;
  logic              err_o;
  logic [DW-1:0]     rdata_o;
  logic              bus_req, bus_start, bus_data_oe;
  logic [AW-1:0]     bus_addr;
  logic [1:0]        bus_mode;
  logic [DW-1:0]     bus_wdata;
  logic              bus_rdy = 1'b0;
  logic [DW-1:0]     bus_rdata = '0;

  ifa_bus_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .addr_i(addr_i), .mode_i(mode_i),
    .wdata_i(wdata_i), .gnt_o(gnt_o), .done_o(done_o), .err_o(err_o),
    .rdata_o(rdata_o), .bus_req(bus_req), .bus_start(bus_start),
    .bus_addr(bus_addr), .bus_mode(bus_mode), .bus_wdata(bus_wdata),
    .bus_data_oe(bus_data_oe), .bus_rdy(bus_rdy), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic [7:0] rdata;
    logic       err;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         checks = 0;
  int         errors = 0;
  int         dly[NREQ];
  int         wcnt = 0;
  bit         rdy_in_start = 1'b0;
  bit         use_fixed = 1'b0;
  logic [7:0] fixed_data = 8'h00;
  logic [7:0] model_rdata = 8'h00;

  function automatic logic [7:0] mem_of(input logic [7:0] a);
    return a ^ 8'hC3;
  endfunction

  function automatic int gnt_idx();
    int r = -1;
    for (int i = 0; i < NREQ; i++) if (gnt_o[i]) r = i;
    return r;
  endfunction

  task automatic push(input int idx, input logic err, input logic upd, input logic [7:0] val);
    if (upd) model_rdata = val;
    sb.push_back('{idx: idx, rdata: model_rdata, err: err});
  endtask

  // One cycle: memory responder, scoreboard pop on completion, requester drop on done.
  task automatic tick();
    int cur;
    @(negedge clk);
    cur = gnt_idx();
    if (bus_start) begin
      wcnt    = 0;
      bus_rdy = rdy_in_start;
    end else if (bus_req) begin
      bus_rdy = (cur >= 0) && (dly[cur] >= 0) && (wcnt == dly[cur]);
      wcnt++;
    end else begin
      bus_rdy = 1'b0;
    end
    bus_rdata = use_fixed ? fixed_data : mem_of(bus_addr);
    if (!rst && (done_o != '0 || err_o)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: done_o=%b err_o=%b, required no completion", done_o, err_o);
      end else begin
        mon_e = sb.pop_front();
        if (done_o !== (NREQ'(1) << mon_e.idx) || err_o !== mon_e.err || rdata_o !== mon_e.rdata) begin
          errors++;
          $display("FAIL completion: done_o=%b err_o=%b rdata_o=%h, required done_o=%b err_o=%b rdata_o=%h",
                   done_o, err_o, rdata_o, NREQ'(1) << mon_e.idx, mon_e.err, mon_e.rdata);
        end
      end
      for (int i = 0; i < NREQ; i++) if (done_o[i]) req_i[i] = 1'b0;
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((sb.size() != 0 || req_i != '0 || bus_req) && n < budget) begin
      tick();
      n++;
    end
    if (sb.size() != 0 || req_i != '0 || bus_req) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: pending=%0d req_i=%b, required all completions within %0d cycles",
               sb.size(), req_i, budget);
      sb.delete();
      req_i = '0;
    end
    repeat (2) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    checks++;
    if (gnt_o !== '0 || done_o !== '0 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: gnt_o=%b done_o=%b err_o=%b, required all 0", gnt_o, done_o, err_o);
    end
    checks++;
    if (rdata_o !== '0) begin
      errors++;
      $display("FAIL reset_rdata: rdata_o=%h, required 00", rdata_o);
    end
    checks++;
    if ({bus_req, bus_start, bus_addr, bus_mode, bus_wdata, bus_data_oe} !== '0) begin
      errors++;
      $display("FAIL reset_bus: req=%b start=%b addr=%h mode=%b wdata=%h oe=%b, required all 0",
               bus_req, bus_start, bus_addr, bus_mode, bus_wdata, bus_data_oe);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (bus_req !== 1'b0) begin
      errors++;
      $display("FAIL idle_quiet: bus_req=%b, required 0 with no requests", bus_req);
    end
  endtask

  task automatic test_round_robin();
    use_fixed = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      dly[i] = 0;
      addr_i[i*AW +: AW] = AW'(16 + i);
      mode_i[i*2 +: 2]   = 2'b00;
    end
    for (int i = 0; i < NREQ; i++) push(i, 1'b0, 1'b1, mem_of(8'(16 + i)));
    req_i = 4'b1111;
    wait_idle(200);
    push(0, 1'b0, 1'b1, mem_of(8'h10));
    push(3, 1'b0, 1'b1, mem_of(8'h13));
    req_i = 4'b1001;
    wait_idle(200);
  endtask

  task automatic test_single_read();
    use_fixed  = 1'b1;
    fixed_data = 8'hA5;
    addr_i[0 +: AW] = 8'h3C;
    mode_i[0 +: 2]  = 2'b00;
    push(0, 1'b0, 1'b1, 8'hA5);
    req_i[0] = 1'b1;
    tick();
    checks++;
    if (bus_start !== 1'b1 || bus_req !== 1'b1 || gnt_o !== 4'b0001) begin
      errors++;
      $display("FAIL read_cycle1: start=%b req=%b gnt_o=%b, required 1 1 0001", bus_start, bus_req, gnt_o);
    end
    checks++;
    if (bus_addr !== 8'h3C || bus_data_oe !== 1'b0) begin
      errors++;
      $display("FAIL read_addr: bus_addr=%h oe=%b, required 3c 0", bus_addr, bus_data_oe);
    end
    tick();
    checks++;
    if (bus_start !== 1'b0 || bus_req !== 1'b1) begin
      errors++;
      $display("FAIL read_cycle2: start=%b req=%b, required 0 1", bus_start, bus_req);
    end
    tick();
    checks++;
    if (done_o !== 4'b0001 || rdata_o !== 8'hA5 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL read_cycle3: done_o=%b rdata_o=%h err_o=%b, required 0001 a5 0", done_o, rdata_o, err_o);
    end
    wait_idle(50);
    use_fixed = 1'b0;
  endtask

  task automatic test_write();
    int n = 0;
    addr_i[2*AW +: AW]  = 8'h77;
    mode_i[2*2 +: 2]    = 2'b01;
    wdata_i[2*DW +: DW] = 8'h5A;
    dly[2] = 3;
    push(2, 1'b0, 1'b0, 8'h00);
    req_i[2] = 1'b1;
    tick();
    while (gnt_o[2] && n < 50) begin
      checks++;
      if (bus_data_oe !== 1'b1 || bus_wdata !== 8'h5A || bus_mode !== 2'b01) begin
        errors++;
        $display("FAIL write_hold: oe=%b wdata=%h mode=%b, required 1 5a 01", bus_data_oe, bus_wdata, bus_mode);
      end
      wdata_i[2*DW +: DW] = 8'h00;
      n++;
      tick();
    end
    checks++;
    if (n !== 5) begin
      errors++;
      $display("FAIL write_len: granted cycles=%0d, required 5", n);
    end
    checks++;
    if (rdata_o !== 8'hA5) begin
      errors++;
      $display("FAIL write_rdata: rdata_o=%h, required a5", rdata_o);
    end
    wait_idle(50);
    dly[2] = 0;
    mode_i[2*2 +: 2] = 2'b00;
  endtask

  task automatic test_timeout();
    int n = 0;
    addr_i[0 +: AW]    = 8'h21;
    addr_i[3*AW +: AW] = 8'hEE;
    dly[3] = -1;
    push(3, 1'b1, 1'b0, 8'h00);
    push(0, 1'b0, 1'b1, mem_of(8'h21));
    req_i = 4'b1001;
    for (int k = 0; k < 10 && !gnt_o[3]; k++) tick();
    while (gnt_o[3] && bus_req && n < 100) begin
      n++;
      tick();
    end
    checks++;
    if (n !== TIMEOUT + 1) begin
      errors++;
      $display("FAIL timeout_len: bus_req cycles=%0d, required %0d", n, TIMEOUT + 1);
    end
    checks++;
    if (done_o !== 4'b1000 || err_o !== 1'b1) begin
      errors++;
      $display("FAIL timeout_done: done_o=%b err_o=%b, required 1000 1", done_o, err_o);
    end
    wait_idle(100);
    dly[3] = 0;
  endtask

  task automatic test_rdy_start();
    int n = 0;
    addr_i[1*AW +: AW] = 8'h44;
    dly[1] = 2;
    rdy_in_start = 1'b1;
    push(1, 1'b0, 1'b1, mem_of(8'h44));
    req_i[1] = 1'b1;
    for (int k = 0; k < 10 && !gnt_o[1]; k++) tick();
    while (gnt_o[1] && n < 50) begin
      n++;
      tick();
    end
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL rdy_start_len: granted cycles=%0d, required 4", n);
    end
    rdy_in_start = 1'b0;
    wait_idle(50);
    dly[1] = 0;
  endtask

  task automatic test_reset_mid();
    addr_i[1*AW +: AW] = 8'h55;
    dly[1] = -1;
    req_i[1] = 1'b1;
    for (int k = 0; k < 10 && !gnt_o[1]; k++) tick();
    repeat (3) tick();
    checks++;
    if (bus_req !== 1'b1 || bus_start !== 1'b0) begin
      errors++;
      $display("FAIL pre_reset_wait: req=%b start=%b, required 1 0", bus_req, bus_start);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (gnt_o !== '0 || done_o !== '0 || err_o !== 1'b0 || rdata_o !== '0) begin
      errors++;
      $display("FAIL async_reset_ctrl: gnt_o=%b done_o=%b err_o=%b rdata_o=%h, required all 0",
               gnt_o, done_o, err_o, rdata_o);
    end
    checks++;
    if ({bus_req, bus_start, bus_addr, bus_mode, bus_wdata, bus_data_oe} !== '0) begin
      errors++;
      $display("FAIL async_reset_bus: req=%b start=%b addr=%h, required all 0", bus_req, bus_start, bus_addr);
    end
    req_i = '0;
    sb.delete();
    model_rdata = 8'h00;
    repeat (2) tick();
    rst = 1'b0;
    dly[1] = 0;
    addr_i[1*AW +: AW] = 8'h61;
    addr_i[2*AW +: AW] = 8'h62;
    push(1, 1'b0, 1'b1, mem_of(8'h61));
    push(2, 1'b0, 1'b1, mem_of(8'h62));
    req_i = 4'b0110;
    wait_idle(100);
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) dly[i] = 0;
    test_reset();
    test_round_robin();
    test_single_read();
    test_write();
    test_timeout();
    test_rdy_start();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required self-termination");
    $fatal(1);
  end

endmodule
`default_nettype wire
